// File: rtl/uart_pkg.sv
// Shared types for the UART stream transceiver.
//   parity_t : parity mode selector (NONE/EVEN/ODD/MARK/SPACE)
package uart_pkg;
   typedef enum logic [2:0] {NONE, EVEN, ODD, MARK, SPACE} parity_t;
endpackage

// File: rtl/uart_stream.sv
// UART transceiver: 16x oversampled RX with 7/8/9 majority vote, runtime baud
// divisor latched per frame, valid/ready streams and per-word error reporting.
// Ports:
//   clk, rst_          clock, asynchronous active-low reset
//   div                oversampling tick period - 1 (bit = 16*(div+1) clocks)
//   tx_data/valid/ready transmit stream (ready only while TX idle)
//   rx_data/valid/ready receive stream, held until accepted
//   rx_parity_err, rx_frame_err  flags of the word currently offered
//   rx_overrun, rx_break         single-cycle event pulses
//   busy               TX or RX FSM not idle
//   rx, tx             serial pins (idle high)
//   loopback           only with UART_LOOPBACK_EN: RX fed from internal TX, tx pin held 1
module uart_stream
   import uart_pkg::*;
#(
   parameter int unsigned DATA_  = 8,
   parameter int unsigned STOP_  = 1,
   parameter parity_t     PARITY = NONE,
   parameter int unsigned DIV_   = 16
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [DIV_-1:0]  div,
   input  logic [DATA_-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic [DATA_-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             rx_parity_err,
   output logic             rx_frame_err,
   output logic             rx_overrun,
   output logic             rx_break,
   output logic             busy,
   input  logic             rx,
`ifdef UART_LOOPBACK_EN
   input  logic             loopback,
`endif
   output logic             tx
);

   localparam int unsigned CNT_W  = DIV_ + 4;
   localparam bit          PAR_EN = (PARITY != NONE);

   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_state_t;

   function automatic logic par_bit(input logic [DATA_-1:0] d);
      case (PARITY)
         EVEN:    return ^d;
         ODD:     return ~^d;
         MARK:    return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // TX state
   tx_state_t        tx_state_q, tx_state_d;
   logic [DIV_-1:0]  tx_div_q, tx_div_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [3:0]       tx_idx_q, tx_idx_d;
   logic [DATA_-1:0] tx_shift_q, tx_shift_d;
   logic             tx_par_q, tx_par_d;
   logic             tx_bit_q, tx_bit_d;
   logic             tx_pin_q, tx_pin_d;
   logic             tx_ready_q, tx_ready_d;

   // RX state
   rx_state_t        rx_state_q, rx_state_d;
   logic             rx_s1_q, rx_s2_q, rx_prev_q;
   logic [DIV_-1:0]  rx_div_q, rx_div_d;
   logic [DIV_-1:0]  rx_pre_q, rx_pre_d;
   logic [3:0]       rx_tick_q, rx_tick_d;
   logic [3:0]       rx_idx_q, rx_idx_d;
   logic [DATA_-1:0] rx_shift_q, rx_shift_d;
   logic             rx_par_q, rx_par_d;
   logic             rx_stop0_q, rx_stop0_d;
   logic             rx_ferr_q, rx_ferr_d;
   logic [1:0]       rx_smp_q, rx_smp_d;

   // RX output registers
   logic [DATA_-1:0] rx_word_q, rx_word_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_perr_q, rx_perr_d;
   logic             rx_ferr_out_q, rx_ferr_out_d;
   logic             rx_ovr_q, rx_ovr_d;
   logic             rx_brk_q, rx_brk_d;
   logic             busy_q, busy_d;

   logic lb_c, rx_in_c, tick_c, maj_c, done_c, brk_c, stop0_c, ferr_c;

`ifdef UART_LOOPBACK_EN
   assign lb_c    = loopback;
   assign rx_in_c = loopback ? tx_bit_q : rx;
`else
   assign lb_c    = 1'b0;
   assign rx_in_c = rx;
`endif

   assign tick_c = (rx_pre_q == rx_div_q);
   // majority of ticks 7, 8 and the live tick-9 sample
   assign maj_c  = (rx_smp_q[0] & rx_smp_q[1]) | (rx_smp_q[0] & rx_s2_q) | (rx_smp_q[1] & rx_s2_q);

   // TX next state: down-counter per bit; last stop ends one clock early so the
   // idle cycle that raises tx_ready is the final stop cycle (no gap back-to-back)
   always_comb begin
      tx_state_d = tx_state_q;
      tx_div_d   = tx_div_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_bit_d   = tx_bit_q;
      tx_ready_d = tx_ready_q;
      case (tx_state_q)
         T_IDLE: begin
            if (tx_valid) begin
               tx_state_d = T_START;
               tx_div_d   = div;
               tx_cnt_d   = {div, 4'hF};
               tx_shift_d = tx_data;
               tx_par_d   = par_bit(tx_data);
               tx_bit_d   = 1'b0;
               tx_ready_d = 1'b0;
            end
         end
         default: begin
            tx_cnt_d = tx_cnt_q - CNT_W'(1);
            if (tx_state_q == T_STOP && tx_idx_q == 4'(STOP_ - 1) && tx_cnt_q == CNT_W'(1)) begin
               tx_state_d = T_IDLE;
               tx_ready_d = 1'b1;
            end else if (tx_cnt_q == '0) begin
               tx_cnt_d = {tx_div_q, 4'hF};
               case (tx_state_q)
                  T_START: begin
                     tx_state_d = T_DATA;
                     tx_idx_d   = '0;
                     tx_bit_d   = tx_shift_q[0];
                     tx_shift_d = tx_shift_q >> 1;
                  end
                  T_DATA: begin
                     if (tx_idx_q == 4'(DATA_ - 1)) begin
                        tx_state_d = PAR_EN ? T_PAR : T_STOP;
                        tx_bit_d   = PAR_EN ? tx_par_q : 1'b1;
                        tx_idx_d   = '0;
                     end else begin
                        tx_idx_d   = tx_idx_q + 4'd1;
                        tx_bit_d   = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                     end
                  end
                  T_PAR: begin
                     tx_state_d = T_STOP;
                     tx_bit_d   = 1'b1;
                     tx_idx_d   = '0;
                  end
                  default: tx_idx_d = tx_idx_q + 4'd1;
               endcase
            end
         end
      endcase
      tx_pin_d = tx_bit_d | lb_c;
   end

   // RX next state and output stage
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_div_d      = rx_div_q;
      rx_pre_d      = rx_pre_q;
      rx_tick_d     = rx_tick_q;
      rx_idx_d      = rx_idx_q;
      rx_shift_d    = rx_shift_q;
      rx_par_d      = rx_par_q;
      rx_stop0_d    = rx_stop0_q;
      rx_ferr_d     = rx_ferr_q;
      rx_smp_d      = rx_smp_q;
      done_c        = 1'b0;
      brk_c         = 1'b0;
      stop0_c       = rx_stop0_q;
      ferr_c        = rx_ferr_q;
      case (rx_state_q)
         R_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               rx_state_d = R_START;
               rx_div_d   = div;
               rx_pre_d   = '0;
               rx_tick_d  = '0;
               rx_ferr_d  = 1'b0;
            end
         end
         R_WAIT: if (rx_s2_q) rx_state_d = R_IDLE;
         default: begin
            rx_pre_d = tick_c ? '0 : rx_pre_q + DIV_'(1);
            if (tick_c) begin
               rx_tick_d = rx_tick_q + 4'd1;
               if (rx_tick_q == 4'd7) rx_smp_d[0] = rx_s2_q;
               if (rx_tick_q == 4'd8) rx_smp_d[1] = rx_s2_q;
               if (rx_tick_q == 4'd9) begin
                  case (rx_state_q)
                     R_START: begin
                        rx_state_d = maj_c ? R_IDLE : R_DATA;
                        rx_idx_d   = '0;
                     end
                     R_DATA: begin
                        rx_shift_d = {maj_c, rx_shift_q[DATA_-1:1]};
                        if (rx_idx_q == 4'(DATA_ - 1)) begin
                           rx_state_d = PAR_EN ? R_PAR : R_STOP;
                           rx_idx_d   = '0;
                        end else begin
                           rx_idx_d = rx_idx_q + 4'd1;
                        end
                     end
                     R_PAR: begin
                        rx_par_d   = maj_c;
                        rx_state_d = R_STOP;
                        rx_idx_d   = '0;
                     end
                     default: begin
                        if (rx_idx_q == '0) stop0_c = maj_c;
                        ferr_c     = rx_ferr_q | ~maj_c;
                        rx_stop0_d = stop0_c;
                        rx_ferr_d  = ferr_c;
                        if (rx_idx_q == 4'(STOP_ - 1)) begin
                           done_c     = 1'b1;
                           brk_c      = (rx_shift_q == '0) && (!PAR_EN || !rx_par_q) && !stop0_c;
                           // after a break or bad stop, re-arm only once the line is high
                           rx_state_d = (brk_c || ferr_c) ? R_WAIT : R_IDLE;
                        end else begin
                           rx_idx_d = rx_idx_q + 4'd1;
                        end
                     end
                  endcase
               end
            end
         end
      endcase

      rx_word_d     = rx_word_q;
      rx_perr_d     = rx_perr_q;
      rx_ferr_out_d = rx_ferr_out_q;
      rx_valid_d    = rx_valid_q & ~rx_ready;
      rx_ovr_d      = 1'b0;
      rx_brk_d      = brk_c;
      if (done_c && !brk_c) begin
         if (rx_valid_q && !rx_ready) begin
            rx_ovr_d = 1'b1;
         end else begin
            rx_valid_d    = 1'b1;
            rx_word_d     = rx_shift_q;
            rx_perr_d     = PAR_EN && (rx_par_q != par_bit(rx_shift_q));
            rx_ferr_out_d = ferr_c;
         end
      end
   end

   assign busy_d = (tx_state_d != T_IDLE) || (rx_state_d != R_IDLE);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         tx_state_q    <= T_IDLE;
         tx_div_q      <= '0;
         tx_cnt_q      <= '0;
         tx_idx_q      <= '0;
         tx_shift_q    <= '0;
         tx_par_q      <= 1'b0;
         tx_bit_q      <= 1'b1;
         tx_pin_q      <= 1'b1;
         tx_ready_q    <= 1'b1;
         rx_state_q    <= R_IDLE;
         rx_s1_q       <= 1'b1;
         rx_s2_q       <= 1'b1;
         rx_prev_q     <= 1'b1;
         rx_div_q      <= '0;
         rx_pre_q      <= '0;
         rx_tick_q     <= '0;
         rx_idx_q      <= '0;
         rx_shift_q    <= '0;
         rx_par_q      <= 1'b0;
         rx_stop0_q    <= 1'b0;
         rx_ferr_q     <= 1'b0;
         rx_smp_q      <= '0;
         rx_word_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_perr_q     <= 1'b0;
         rx_ferr_out_q <= 1'b0;
         rx_ovr_q      <= 1'b0;
         rx_brk_q      <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         tx_state_q    <= tx_state_d;
         tx_div_q      <= tx_div_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_idx_q      <= tx_idx_d;
         tx_shift_q    <= tx_shift_d;
         tx_par_q      <= tx_par_d;
         tx_bit_q      <= tx_bit_d;
         tx_pin_q      <= tx_pin_d;
         tx_ready_q    <= tx_ready_d;
         rx_state_q    <= rx_state_d;
         rx_s1_q       <= rx_in_c;
         rx_s2_q       <= rx_s1_q;
         rx_prev_q     <= rx_s2_q;
         rx_div_q      <= rx_div_d;
         rx_pre_q      <= rx_pre_d;
         rx_tick_q     <= rx_tick_d;
         rx_idx_q      <= rx_idx_d;
         rx_shift_q    <= rx_shift_d;
         rx_par_q      <= rx_par_d;
         rx_stop0_q    <= rx_stop0_d;
         rx_ferr_q     <= rx_ferr_d;
         rx_smp_q      <= rx_smp_d;
         rx_word_q     <= rx_word_d;
         rx_valid_q    <= rx_valid_d;
         rx_perr_q     <= rx_perr_d;
         rx_ferr_out_q <= rx_ferr_out_d;
         rx_ovr_q      <= rx_ovr_d;
         rx_brk_q      <= rx_brk_d;
         busy_q        <= busy_d;
      end
   end

   assign tx            = tx_pin_q;
   assign tx_ready      = tx_ready_q;
   assign rx_data       = rx_word_q;
   assign rx_valid      = rx_valid_q;
   assign rx_parity_err = rx_perr_q;
   assign rx_frame_err  = rx_ferr_out_q;
   assign rx_overrun    = rx_ovr_q;
   assign rx_break      = rx_brk_q;
   assign busy          = busy_q;

endmodule

// File: doc/uart_stream.md
# uart_stream

Parametrised UART transceiver with 16x oversampling, a runtime baud divisor, valid/ready streams on both directions, and per-word error reporting. It sits between the `rx`/`tx` pins and a FIFO or bus adapter in the COM sector. It replaces fixed-rate, FIFO-coupled UART cores wherever the baud rate must change at runtime or line errors must reach software.

## Interface
- `DATA_`, default 8: data bits per frame, 5..9, sent LSB first.
- `STOP_`, default 1: stop bits, 1..2.
- `PARITY`, default NONE: parity mode, `parity_t` from `uart_pkg`, one of NONE/EVEN/ODD/MARK/SPACE.
- `DIV_`, default 16: width of the baud divisor input.
- `clk` in 1: clock.
- `rst_` in 1: asynchronous active-low reset.
- `div` in DIV_: oversampling tick period minus one. Bit period = 16*(div+1) clocks.
- `tx_data` in DATA_: word to send.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: transmitter is idle and accepts a word.
- `rx_data` out DATA_: received word.
- `rx_valid` out 1: `rx_data` and the error flags are valid.
- `rx_ready` in 1: consumer accepts the received word.
- `rx_parity_err` out 1: parity mismatch on the word currently offered.
- `rx_frame_err` out 1: a stop bit sampled 0 on the word currently offered.
- `rx_overrun` out 1: one-cycle pulse when a completed word is dropped.
- `rx_break` out 1: one-cycle pulse when a break is detected.
- `busy` out 1: TX or RX FSM is not IDLE.
- `rx` in 1: serial input.
- `tx` out 1: serial output, idle high.

## Operation
- **TX FSM**: IDLE -> START -> DATA -> PARITY (skipped if NONE) -> STOP -> IDLE.
  - A word is accepted on `tx_valid && tx_ready`. `tx_ready` = 1 only in IDLE.
  - On acceptance, `div` is latched and the TX prescaler restarts.
  - Each bit lasts exactly 16*(latched div+1) clocks.
- **Parity bit**:
  - EVEN: bit makes the total ones over data+parity even.
  - ODD: bit makes that total odd.
  - MARK: bit = 1.
  - SPACE: bit = 0.
- **RX synchroniser**: `rx` passes through a 2-flop synchroniser.
- **RX FSM**: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE detects a synchronised 1->0 transition, latches `div`, and restarts the RX prescaler.
  - Each bit is decided by majority vote of samples at ticks 7, 8 and 9 of its 16 ticks. The decision is made at tick 9.
  - If the START majority is 1, it is a false start: return to IDLE with no output.
  - Each STOP bit is checked. Any 0 sets the frame error for that word.
- **Word delivery**: after the last stop decision, `rx_data`, `rx_parity_err` and `rx_frame_err` load and `rx_valid` = 1. The FSM returns to IDLE immediately, mid stop bit.
- **After a frame error**: IDLE waits for a synchronised 1 before re-arming.
- **Break**: all data bits 0, parity 0 (if present), and first stop 0. Pulse `rx_break`, deliver no word, then wait for the line to return high.
- **Output hold**: `rx_valid` and its data/flags are held until `rx_ready`.
- **Overrun**: a new word completing while an unaccepted word is held is dropped, and `rx_overrun` pulses. If `rx_ready` = 1 in that same cycle, the held word is consumed, the new word loads, and there is no overrun.
- **Divisor changes**: changing `div` mid-frame has no effect until the next frame. `div` = 0 is legal (16 clocks/bit).
- **Reset values**, applied asynchronously, including mid-frame:
  - `tx` = 1, `tx_ready` = 1.
  - `rx_valid`, `rx_data`, all error flags and `busy` = 0.
  - Both FSMs go to IDLE and both prescalers clear.
- A partial frame in flight at reset is discarded.

## Timing
- `tx` drives the start bit (0) from the cycle after acceptance.
- `tx_ready` is low from the cycle after acceptance.
- Frame length is N = 1+DATA_+PARITY_+STOP_ bits; PARITY_ = 1 unless PARITY = NONE, else 0.
- `tx_ready` is high again N*16*(div+1) clocks after acceptance. Back-to-back words therefore produce no idle gap.
- RX start is detected 2 clocks after the pin falls (synchroniser).
- `rx_valid` rises 1 clock after the tick-9 decision of the last stop bit.
- `rx_break` and `rx_overrun` pulses coincide with that cycle.
- Receiver tolerance: ±3% combined baud mismatch.

## Configuration
- `UART_LOOPBACK_EN`:
  - Defined: adds input port `loopback`, 1 bit, placed after `rx`. When `loopback` = 1, the RX synchroniser input is the internal TX bit stream and the external `tx` pin is held at 1. When 0, behaviour is normal.
  - Undefined: no `loopback` port. RX always samples the `rx` pin.

## Test plan
Common configuration unless stated: DATA_=8, STOP_=1, div=1 (32 clk/bit).

- **TX frame (PARITY=EVEN)**: send 0xA5.
  - `tx` = 0,1,0,1,0,0,1,0,1,0,1, each held 32 clocks.
  - `tx_ready` returns high 352 clocks after acceptance.
- **RX with parity error (PARITY=ODD)**: drive the 0x3C frame with the parity bit inverted.
  - `rx_data` = 0x3C, `rx_valid` = 1, `rx_parity_err` = 1, `rx_frame_err` = 0.
- **Overrun**: with `rx_ready` held 0, receive 0x11 then 0x22.
  - `rx_data` stays 0x11.
  - `rx_overrun` pulses once, 1 clock after the second frame's stop decision.
- **Break**: hold `rx` low for 20 bit periods.
  - One `rx_break` pulse, no `rx_valid`.
  - The next valid frame (0x55) is received correctly after the line returns high.
- **False start**: low glitch on `rx` of 4 clocks.
  - No output; `busy` returns to 0 after the tick-9 decision.
- **Async reset mid-TX**: assert `rst_` during data bit 3.
  - `tx` = 1 and `tx_ready` = 1 immediately.
  - A new word is accepted the first cycle after release.
